// File: rtl/dct_pre_fft_reod.sv
// dct_pre_fft_reod: forward-DCT input reorder into even/odd-folded order.
// Two-bank ping-pong RAM with a 2-entry output skid.
module dct_pre_fft_reod #(
    parameter int wData = 16,
    parameter int wAddr = 11
) (
    input  logic             clk,
    input  logic             rst_sync,
    input  logic             sink_valid,
    output logic             sink_ready,
    input  logic [1:0]       sink_error,
    input  logic             sink_sop,
    input  logic             sink_eop,
    input  logic [wData-1:0] sink_real,
    input  logic [wData-1:0] sink_imag,
    input  logic [11:0]      fftpts_in,
    output logic             source_valid,
    input  logic             source_ready,
    output logic [1:0]       source_error,
    output logic             source_sop,
    output logic             source_eop,
    output logic [wData-1:0] source_real,
    output logic [wData-1:0] source_imag,
    output logic [11:0]      fftpts_out
);
    localparam int DEPTH = 1 << wAddr;
    localparam logic [wAddr-1:0] ONE = 1;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_t;

    bank_st_t    st [2];
    bank_st_t    st_n [2];
    logic [11:0] bank_len [2];
    logic [1:0]  bank_err [2];
    logic        wb, rb, wb_n, rb_n;
    logic [11:0] wk, ra;
    logic [1:0]  wacc;

    logic             accept, wr_live, in_range, we;
    logic             rd_go, rd_last, room, out_load;
    logic [11:0]      wn, wk_cur, rn;
    logic [1:0]       acc_nx, fin_err, used;
    logic [wAddr-1:0] waddr, wlo, kh;

    logic [2*wData-1:0] mem [2*DEPTH];
    logic [2*wData-1:0] rdata;
    logic               rd_vld, rd_sop, rd_eop;
    logic [1:0]         rd_err;
    logic [11:0]        rd_len;

    logic               sk_vld, sk_sop, sk_eop;
    logic [1:0]         sk_err;
    logic [11:0]        sk_len;
    logic [2*wData-1:0] sk_data;

    always_comb begin
        accept   = sink_valid & sink_ready;
        wn       = sink_sop ? fftpts_in : bank_len[wb];
        wk_cur   = sink_sop ? 12'd0 : wk;
        wr_live  = accept & (sink_sop | (st[wb] == FILLING));
        in_range = wk_cur < wn;
        we       = wr_live & in_range;
        // even k fills from the bottom, odd k from the top down
        wlo      = wn[wAddr-1:0];
        kh       = wk_cur[wAddr:1];
        waddr    = wk_cur[0] ? wlo - ONE - kh : kh;
        acc_nx   = (sink_sop ? 2'b00 : wacc) | sink_error
                 | (in_range ? 2'b00 : 2'b10);
        fin_err  = acc_nx | ((wk_cur < wn - 12'd1) ? 2'b01 : 2'b00);

        rn       = bank_len[rb];
        rd_last  = ra == rn - 12'd1;
        // words held after this cycle plus the read in flight
        used     = 2'(source_valid & ~source_ready) + 2'(sk_vld)
                 + 2'(rd_vld);
        room     = used < 2'd2;
        rd_go    = room & ((st[rb] == FULL) | (st[rb] == DRAINING));
        out_load = ~source_valid | source_ready;

        st_n[0] = st[0];
        st_n[1] = st[1];
        if (wr_live) st_n[wb] = sink_eop ? FULL : FILLING;
        if (rd_go)   st_n[rb] = rd_last ? EMPTY : DRAINING;
        wb_n = wb ^ (wr_live & sink_eop);
        rb_n = rb ^ (rd_go & rd_last);
    end

    always_ff @(posedge clk) begin
        if (we) mem[{wb, waddr}] <= {sink_real, sink_imag};
        if (rd_go) rdata <= mem[{rb, ra[wAddr-1:0]}];
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            st[0]        <= EMPTY;
            st[1]        <= EMPTY;
            bank_len[0]  <= '0;
            bank_len[1]  <= '0;
            bank_err[0]  <= '0;
            bank_err[1]  <= '0;
            wb           <= 1'b0;
            rb           <= 1'b0;
            wk           <= '0;
            wacc         <= '0;
            ra           <= '0;
            sink_ready   <= 1'b0;
            rd_vld       <= 1'b0;
            rd_sop       <= 1'b0;
            rd_eop       <= 1'b0;
            rd_err       <= '0;
            rd_len       <= '0;
            sk_vld       <= 1'b0;
            sk_sop       <= 1'b0;
            sk_eop       <= 1'b0;
            sk_err       <= '0;
            sk_len       <= '0;
            sk_data      <= '0;
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            source_error <= '0;
            source_real  <= '0;
            source_imag  <= '0;
            fftpts_out   <= '0;
        end else begin
            st[0]      <= st_n[0];
            st[1]      <= st_n[1];
            wb         <= wb_n;
            rb         <= rb_n;
            sink_ready <= (st_n[wb_n] == EMPTY) | (st_n[wb_n] == FILLING);

            if (wr_live) begin
                if (sink_sop) bank_len[wb] <= fftpts_in;
                wk   <= in_range ? wk_cur + 12'd1 : wk_cur;
                wacc <= acc_nx;
                if (sink_eop) bank_err[wb] <= fin_err;
            end

            rd_vld <= rd_go;
            if (rd_go) begin
                ra     <= rd_last ? 12'd0 : ra + 12'd1;
                rd_sop <= ra == 12'd0;
                rd_eop <= rd_last;
                rd_err <= bank_err[rb];
                rd_len <= rn;
            end

            if (out_load) begin
                if (sk_vld) begin
                    source_valid               <= 1'b1;
                    {source_real, source_imag} <= sk_data;
                    source_sop                 <= sk_sop;
                    source_eop                 <= sk_eop;
                    source_error               <= sk_err;
                    fftpts_out                 <= sk_len;
                end else begin
                    source_valid <= rd_vld;
                    if (rd_vld) begin
                        {source_real, source_imag} <= rdata;
                        source_sop                 <= rd_sop;
                        source_eop                 <= rd_eop;
                        source_error               <= rd_err;
                        fftpts_out                 <= rd_len;
                    end
                end
            end

            if (out_load & sk_vld & ~rd_vld) sk_vld <= 1'b0;
            if (rd_vld & (~out_load | sk_vld)) begin
                sk_vld  <= 1'b1;
                sk_data <= rdata;
                sk_sop  <= rd_sop;
                sk_eop  <= rd_eop;
                sk_err  <= rd_err;
                sk_len  <= rd_len;
            end
        end
    end
endmodule

// File: tb/tb_dct_pre_fft_reod.sv
// tb_dct_pre_fft_reod: random frames checked against a fold-order
// queue model; stall hold, latency, gap and reset behaviour.
module tb_dct_pre_fft_reod;
    logic        clk = 1'b0;
    logic        rst_sync = 1'b1;
    logic        sink_valid = 1'b0;
    logic        sink_ready;
    logic [1:0]  sink_error = '0;
    logic        sink_sop = 1'b0;
    logic        sink_eop = 1'b0;
    logic [15:0] sink_real = '0;
    logic [15:0] sink_imag = '0;
    logic [11:0] fftpts_in = '0;
    logic        source_valid;
    logic        source_ready = 1'b1;
    logic [1:0]  source_error;
    logic        source_sop;
    logic        source_eop;
    logic [15:0] source_real;
    logic [15:0] source_imag;
    logic [11:0] fftpts_out;

    dct_pre_fft_reod #(.wData(16), .wAddr(11)) dut (
        .clk(clk),
        .rst_sync(rst_sync),
        .sink_valid(sink_valid),
        .sink_ready(sink_ready),
        .sink_error(sink_error),
        .sink_sop(sink_sop),
        .sink_eop(sink_eop),
        .sink_real(sink_real),
        .sink_imag(sink_imag),
        .fftpts_in(fftpts_in),
        .source_valid(source_valid),
        .source_ready(source_ready),
        .source_error(source_error),
        .source_sop(source_sop),
        .source_eop(source_eop),
        .source_real(source_real),
        .source_imag(source_imag),
        .fftpts_out(fftpts_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        dc;
        logic [15:0] ctl;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   passed = 0;
    int   failed = 0;
    int   cyc = 0;
    int   eop_cyc = 0;
    int   first_sop_cyc = -1;
    int   last_eop_cyc = -1;
    bit   gap_chk = 1'b0;
    bit   rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        source_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic [48:0] prev_out = '0;
    bit          prev_stall = 1'b0;

    always @(negedge clk) begin
        logic [48:0] cur;
        exp_t        e;
        cur = {source_valid, source_sop, source_eop, source_error,
               fftpts_out, source_real, source_imag};
        if (prev_stall) begin
            total++;
            assert (cur === prev_out) passed++;
            else begin
                failed++;
                $error("FAIL stall_hold got %h want %h", cur, prev_out);
            end
        end
        prev_out   = cur;
        prev_stall = source_valid & ~source_ready;
        if (source_valid && source_ready) begin
            total++;
            assert (exp_q.size() > 0) passed++;
            else begin
                failed++;
                $error("FAIL spurious_word got real=%h want no word",
                       source_real);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                assert ({source_sop, source_eop, source_error,
                         fftpts_out} === e.ctl) passed++;
                else begin
                    failed++;
                    $error("FAIL ctl got %h want %h",
                           {source_sop, source_eop, source_error,
                            fftpts_out}, e.ctl);
                end
                if (!e.dc) begin
                    total++;
                    assert ({source_real, source_imag} === e.data) passed++;
                    else begin
                        failed++;
                        $error("FAIL data got %h want %h",
                               {source_real, source_imag}, e.data);
                    end
                end
                if (source_sop && first_sop_cyc < 0) first_sop_cyc = cyc;
                if (source_sop && gap_chk && last_eop_cyc >= 0) begin
                    total++;
                    assert (cyc - last_eop_cyc - 1 <= 2) passed++;
                    else begin
                        failed++;
                        $error("FAIL out_gap got %0d want <=2",
                               cyc - last_eop_cyc - 1);
                    end
                end
                if (source_eop) last_eop_cyc = cyc;
            end
        end
    end

    task automatic send_word(input logic sop, input logic eop,
                             input logic [1:0] err, input logic [31:0] d,
                             output int waited);
        sink_valid = 1'b1;
        sink_sop   = sop;
        sink_eop   = eop;
        sink_error = err;
        {sink_real, sink_imag} = d;
        waited = 0;
        forever begin
            @(negedge clk);
            if (sink_ready) break;
            waited++;
            if (waited > 4000) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
        sink_error = 2'b00;
    endtask

    task automatic send_frame(input int n, input int len, input int err_k,
                              input logic [1:0] err_v, input bit ramp,
                              input bit need_ready);
        logic [31:0] x[$];
        int          ord[$];
        logic [1:0]  acc;
        logic [31:0] d;
        logic [1:0]  er;
        int          w, wsum, wmax;
        exp_t        e;
        acc  = 2'b00;
        wsum = 0;
        wmax = 0;
        fftpts_in = 12'(n);
        for (int k = 0; k < len; k++) begin
            d  = ramp ? {16'(k), ~16'(k)} : $urandom;
            er = (k == err_k) ? err_v : 2'b00;
            x.push_back(d);
            acc |= er;
            send_word(k == 0, k == len - 1, er, d, w);
            wsum += w;
            if (w > wmax) wmax = w;
        end
        eop_cyc = cyc;
        total++;
        assert (wmax <= 4000) passed++;
        else begin
            failed++;
            $error("FAIL sink_timeout got %0d want <=4000", wmax);
        end
        if (len < n) acc |= 2'b01;
        if (len > n) acc |= 2'b10;
        for (int k = 0; k < n; k += 2) ord.push_back(k);
        for (int k = n - 1; k >= 1; k -= 2) ord.push_back(k);
        for (int j = 0; j < n; j++) begin
            e.dc = ord[j] >= len;
            e.data = 32'h0;
            if (!e.dc) e.data = x[ord[j]];
            e.ctl = {j == 0, j == n - 1, acc, 12'(n)};
            exp_q.push_back(e);
        end
        if (need_ready) begin
            total++;
            assert (wsum === 0) passed++;
            else begin
                failed++;
                $error("FAIL sink_ready_drop got %0d stalls want 0", wsum);
            end
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        repeat (8) @(negedge clk);
        total++;
        assert (exp_q.size() === 0) passed++;
        else begin
            failed++;
            $error("FAIL drain got %0d left want 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        assert ({sink_ready, source_valid, source_sop, source_eop,
                 source_error, source_real, source_imag,
                 fftpts_out} === '0) passed++;
        else begin
            failed++;
            $error("FAIL reset_outs got %b want 0",
                   {sink_ready, source_valid, source_sop, source_eop});
        end
        @(posedge clk);
        #1 rst_sync = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        assert (sink_ready === 1'b1) passed++;
        else begin
            failed++;
            $error("FAIL ready_rise got %b want 1", sink_ready);
        end
        @(posedge clk);
        #1;

        send_frame(8, 8, -1, 2'b00, 1'b1, 1'b0);
        wait_drain();
        total++;
        assert (first_sop_cyc - eop_cyc === 2) passed++;
        else begin
            failed++;
            $error("FAIL latency got %0d want 2", first_sop_cyc - eop_cyc);
        end

        gap_chk = 1'b1;
        last_eop_cyc = -1;
        repeat (4) send_frame(16, 16, -1, 2'b00, 1'b0, 1'b1);
        wait_drain();
        gap_chk = 1'b0;

        send_frame(8, 8, -1, 2'b00, 1'b0, 1'b0);
        send_frame(32, 32, -1, 2'b00, 1'b0, 1'b0);
        send_frame(8, 8, -1, 2'b00, 1'b0, 1'b0);
        wait_drain();

        rand_ready = 1'b1;
        repeat (3) send_frame(64, 64, -1, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            int n;
            n = 1 << $urandom_range(2, 8);
            send_frame(n, n, -1, 2'b00, 1'b0, 1'b0);
        end
        wait_drain();
        rand_ready = 1'b0;

        send_frame(8, 6, -1, 2'b00, 1'b0, 1'b0);
        send_frame(8, 8, 3, 2'b10, 1'b0, 1'b0);
        send_frame(4, 6, -1, 2'b00, 1'b0, 1'b0);
        wait_drain();

        fftpts_in = 12'd16;
        for (int k = 0; k < 5; k++) begin
            int w;
            send_word(k == 0, 1'b0, 2'b00, $urandom, w);
        end
        rst_sync = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        assert ({sink_ready, source_valid, source_error,
                 fftpts_out} === '0) passed++;
        else begin
            failed++;
            $error("FAIL midreset got %h want 0",
                   {sink_ready, source_valid, source_error, fftpts_out});
        end
        @(posedge clk);
        #1 rst_sync = 1'b0;
        send_frame(8, 8, -1, 2'b00, 1'b0, 1'b0);
        wait_drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
